// File: rtl/image_present_ctrl.sv
// Image presentation controller: sequences image handshake, encoder clear/enable
// windows and rest gaps for a spiking encoder. Optional freeze input via PRESENT_PAUSE_EN.
module image_present_ctrl #(
  parameter int CNT_W  = 16,
  parameter int REST_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_images,
  input  logic [CNT_W-1:0]  cycles_per_image,
  input  logic [REST_W-1:0] rest_cycles,
  input  logic              img_valid,
`ifdef PRESENT_PAUSE_EN
  input  logic              pause,
`endif
  output logic              img_ready,
  output logic              enc_enable,
  output logic              enc_clear,
  output logic              image_done,
  output logic              run_done,
  output logic              busy,
  output logic [CNT_W-1:0]  image_index,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IMG,
    S_CLEAR,
    S_PRESENT,
    S_REST,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    num_q, num_d;
  logic [CNT_W-1:0]    cpi_q, cpi_d;
  logic [REST_W-1:0]   rest_q, rest_d;
  logic [REST_W-1:0]   rest_cnt_q, rest_cnt_d;
  logic [CNT_W-1:0]    index_q, index_d;
  logic [CNT_W-1:0]    ccount_q, ccount_d;
  logic                image_done_q, image_done_d;
  logic                run_done_q, run_done_d;

  logic                hold;
  logic [CNT_W-1:0]    cpi_last;
  logic                last_cycle;
  logic                last_image;

`ifdef PRESENT_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // A latched length of zero is treated as a one-cycle presentation.
  assign cpi_last   = (cpi_q == '0) ? '0 : cpi_q - CNT_W'(1);
  assign last_cycle = (ccount_q == cpi_last);
  assign last_image = (index_q == num_q - CNT_W'(1));

  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    cpi_d        = cpi_q;
    rest_d       = rest_q;
    rest_cnt_d   = rest_cnt_q;
    index_d      = index_q;
    ccount_d     = ccount_q;
    image_done_d = 1'b0;
    run_done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d    = num_images;
          cpi_d    = cycles_per_image;
          rest_d   = rest_cycles;
          index_d  = '0;
          ccount_d = '0;
          state_d  = (num_images == '0) ? S_DONE : S_WAIT_IMG;
        end
      end
      S_WAIT_IMG: begin
        if (img_valid) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        ccount_d = '0;
        state_d  = S_PRESENT;
      end
      S_PRESENT: begin
        if (!hold) begin
          ccount_d = ccount_q + CNT_W'(1);
          if (last_cycle) begin
            image_done_d = 1'b1;
            if (last_image) begin
              state_d = S_DONE;
            end else begin
              index_d = index_q + CNT_W'(1);
              if (rest_q != '0) begin
                rest_cnt_d = rest_q;
                state_d    = S_REST;
              end else begin
                state_d = S_WAIT_IMG;
              end
            end
          end
        end
      end
      S_REST: begin
        if (!hold) begin
          rest_cnt_d = rest_cnt_q - REST_W'(1);
          if (rest_cnt_q == REST_W'(1)) state_d = S_WAIT_IMG;
        end
      end
      S_DONE: begin
        // First DONE cycle arms the registered run_done pulse; the second emits it.
        if (run_done_q) state_d = S_IDLE;
        else            run_done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      num_q        <= '0;
      cpi_q        <= '0;
      rest_q       <= '0;
      rest_cnt_q   <= '0;
      index_q      <= '0;
      ccount_q     <= '0;
      image_done_q <= 1'b0;
      run_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      cpi_q        <= cpi_d;
      rest_q       <= rest_d;
      rest_cnt_q   <= rest_cnt_d;
      index_q      <= index_d;
      ccount_q     <= ccount_d;
      image_done_q <= image_done_d;
      run_done_q   <= run_done_d;
    end
  end

  assign img_ready   = (state_q == S_WAIT_IMG);
  assign enc_enable  = (state_q == S_PRESENT) && !hold;
  assign enc_clear   = (state_q == S_CLEAR);
  assign busy        = (state_q != S_IDLE);
  assign image_done  = image_done_q;
  assign run_done    = run_done_q;
  assign image_index = index_q;
  assign cycle_count = ccount_q;

endmodule

// File: tb/tb_image_present_ctrl.sv
// Self-checking bench for image_present_ctrl: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized runs.
module tb_image_present_ctrl;
  localparam int CNT_W  = 16;
  localparam int REST_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              img_valid = 1'b0;
  logic [CNT_W-1:0]  num_images = '0;
  logic [CNT_W-1:0]  cycles_per_image = '0;
  logic [REST_W-1:0] rest_cycles = '0;
`ifdef PRESENT_PAUSE_EN
  logic              pause = 1'b0;
`endif
  logic              img_ready, enc_enable, enc_clear, image_done, run_done, busy;
  logic [CNT_W-1:0]  image_index, cycle_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  image_present_ctrl #(.CNT_W(CNT_W), .REST_W(REST_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .num_images(num_images), .cycles_per_image(cycles_per_image),
    .rest_cycles(rest_cycles), .img_valid(img_valid),
`ifdef PRESENT_PAUSE_EN
    .pause(pause),
`endif
    .img_ready(img_ready), .enc_enable(enc_enable), .enc_clear(enc_clear),
    .image_done(image_done), .run_done(run_done), .busy(busy),
    .image_index(image_index), .cycle_count(cycle_count)
  );

  function automatic bit pause_now();
`ifdef PRESENT_PAUSE_EN
    return pause;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural model: phase plus remaining-work counters.
  typedef enum int {M_IDLE, M_WAIT, M_CLEAR, M_PRESENT, M_REST, M_DONE1, M_DONE2} mph_t;
  mph_t m_ph = M_IDLE;
  int   m_n = 0, m_cpi = 0, m_rest = 0, m_img = 0, m_cc = 0, m_left = 0, m_rleft = 0;
  bit   m_idone = 1'b0;

  initial begin : model
    bit idn;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_ph = M_IDLE; m_n = 0; m_cpi = 0; m_rest = 0; m_img = 0;
        m_cc = 0; m_left = 0; m_rleft = 0; m_idone = 1'b0;
      end else begin
        idn = 1'b0;
        case (m_ph)
          M_IDLE: if (start) begin
            m_n    = {16'd0, num_images};
            m_cpi  = {16'd0, cycles_per_image};
            m_rest = {24'd0, rest_cycles};
            m_img  = 0;
            m_cc   = 0;
            m_ph   = (m_n == 0) ? M_DONE1 : M_WAIT;
          end
          M_WAIT: if (img_valid) m_ph = M_CLEAR;
          M_CLEAR: begin
            m_cc   = 0;
            m_left = (m_cpi == 0) ? 1 : m_cpi;
            m_ph   = M_PRESENT;
          end
          M_PRESENT: if (!pause_now()) begin
            m_cc++;
            m_left--;
            if (m_left == 0) begin
              idn = 1'b1;
              if (m_img == m_n - 1) m_ph = M_DONE1;
              else begin
                m_img++;
                if (m_rest > 0) begin m_rleft = m_rest; m_ph = M_REST; end
                else m_ph = M_WAIT;
              end
            end
          end
          M_REST: if (!pause_now()) begin
            m_rleft--;
            if (m_rleft == 0) m_ph = M_WAIT;
          end
          M_DONE1: m_ph = M_DONE2;
          default: m_ph = M_IDLE;
        endcase
        m_idone = idn;
      end
    end
  end

  // Per-scenario statistics gathered alongside the per-cycle comparison.
  int cyc_n = 0, st_cyc = 0;
  int s_en, s_bursts, s_noclr, s_idone, s_rdone, s_busy, s_clr, s_ready;
  int s_rise1, s_rise2, s_idone_cyc;
  bit prev_en = 1'b0, prev_clr = 1'b0;

  task automatic clear_stats();
    s_en = 0; s_bursts = 0; s_noclr = 0; s_idone = 0; s_rdone = 0;
    s_busy = 0; s_clr = 0; s_ready = 0; s_rise1 = -1; s_rise2 = -1; s_idone_cyc = -1;
  endtask

  initial begin : cmp
    logic [5:0] eb, ab;
    forever begin
      @(negedge clk);
      cyc_n++;
      eb = {m_ph == M_WAIT, (m_ph == M_PRESENT) && !pause_now(), m_ph == M_CLEAR,
            m_ph != M_IDLE, m_idone, m_ph == M_DONE2};
      ab = {img_ready, enc_enable, enc_clear, busy, image_done, run_done};
      checks++;
      if (eb !== ab || image_index !== CNT_W'(m_img) || cycle_count !== CNT_W'(m_cc)) begin
        errors++;
        $display("FAIL cycle_compare @%0d: flags(rdy,en,clr,busy,idone,rdone) got %b exp %b index got %0d exp %0d count got %0d exp %0d",
                 cyc_n, ab, eb, image_index, m_img, cycle_count, m_cc);
      end
      if (enc_enable) s_en++;
      if (enc_enable && !prev_en) begin
        s_bursts++;
        if (!prev_clr) s_noclr++;
        if (s_rise1 < 0) s_rise1 = cyc_n;
        else if (s_rise2 < 0) s_rise2 = cyc_n;
      end
      if (image_done) begin s_idone++; if (s_idone_cyc < 0) s_idone_cyc = cyc_n; end
      if (run_done) s_rdone++;
      if (busy) s_busy++;
      if (enc_clear) s_clr++;
      if (img_ready) s_ready++;
      prev_en  = enc_enable;
      prev_clr = enc_clear;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_start(input int n, input int cpi, input int rest);
    num_images       = CNT_W'(n);
    cycles_per_image = CNT_W'(cpi);
    rest_cycles      = REST_W'(rest);
    start = 1'b1;
    step(1);
    start = 1'b0;
    st_cyc = cyc_n;
    num_images       = CNT_W'($urandom);
    cycles_per_image = CNT_W'($urandom);
    rest_cycles      = REST_W'($urandom);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) return;
      step(1);
    end
    chk({nm, "_timeout"}, 1, 0);
  endtask

  initial begin : stim
    clear_stats();
    // Reset state
    step(3);
    chk("rst_busy", busy, 0);
    chk("rst_enable", enc_enable, 0);
    chk("rst_count", cycle_count, 0);
    reset = 1'b1;

    // Two images, 5 cycles each, 3-cycle rest
    img_valid = 1'b1;
    clear_stats();
    do_start(2, 5, 3);
    wait_idle("two_img", 200);
    chk("two_img_en", s_en, 10);
    chk("two_img_bursts", s_bursts, 2);
    chk("two_img_first_rise", s_rise1 - st_cyc, 3);
    chk("two_img_rise_gap", s_rise2 - s_rise1, 10);
    chk("two_img_idone", s_idone, 2);
    chk("two_img_rdone", s_rdone, 1);
    chk("two_img_busy", s_busy, 19);
    chk("two_img_index", image_index, 1);
    chk("two_img_count", cycle_count, 5);

    // Zero images
    clear_stats();
    do_start(0, 4, 2);
    wait_idle("zero_img", 20);
    chk("zero_busy", s_busy, 2);
    chk("zero_rdone", s_rdone, 1);
    chk("zero_en", s_en, 0);

    // Zero-length presentations, no rest
    clear_stats();
    do_start(3, 0, 0);
    wait_idle("zero_len", 100);
    chk("zlen_en", s_en, 3);
    chk("zlen_bursts", s_bursts, 3);
    chk("zlen_noclear", s_noclr, 0);
    chk("zlen_clr", s_clr, 3);
    chk("zlen_idone", s_idone, 3);
    chk("zlen_busy", s_busy, 11);

    // Image source withholds valid
    img_valid = 1'b0;
    do_start(1, 2, 5);
    clear_stats();
    step(10);
    chk("stall_ready", s_ready, 10);
    chk("stall_en", s_en, 0);
    chk("stall_clr", s_clr, 0);
    img_valid = 1'b1;
    wait_idle("stall", 50);
    chk("stall_en_after", s_en, 2);
    chk("stall_rdone", s_rdone, 1);

    // Asynchronous reset during the third PRESENT cycle
    do_start(1, 10, 0);
    step(4);
    chk("arst_pre_en", enc_enable, 1);
    chk("arst_pre_count", cycle_count, 2);
    #2 reset = 1'b0;
    #1;
    chk("arst_flags", {26'd0, img_ready, enc_enable, enc_clear, image_done, run_done, busy}, 0);
    chk("arst_index", image_index, 0);
    chk("arst_count", cycle_count, 0);
    clear_stats();
    step(3);
    reset = 1'b1;
    do_start(2, 3, 1);
    chk("arst_restart_busy", busy, 1);
    wait_idle("arst_restart", 100);
    chk("arst_en", s_en, 6);
    chk("arst_idone", s_idone, 2);
    chk("arst_rdone", s_rdone, 1);

    // Full-width counters
    clear_stats();
    do_start(1, 300, 0);
    wait_idle("long_img", 400);
    chk("long_en", s_en, 300);
    chk("long_count", cycle_count, 300);
    clear_stats();
    do_start(2, 1, 255);
    wait_idle("long_rest", 400);
    chk("long_rest_busy", s_busy, 263);

`ifdef PRESENT_PAUSE_EN
    // Pause four cycles in the middle of a presentation
    clear_stats();
    do_start(1, 6, 0);
    step(4);
    pause = 1'b1;
    step(4);
    pause = 1'b0;
    wait_idle("pause", 100);
    chk("pause_en", s_en, 6);
    chk("pause_idone_at", s_idone_cyc - st_cyc, 13);
    chk("pause_idone", s_idone, 1);
`endif

    // Randomized runs with start spam, random valid and random config
    for (int r = 0; r < 40; r++) begin
      int budget;
      do_start($urandom_range(0, 4), $urandom_range(0, 6), $urandom_range(0, 4));
      budget = 2000;
      while (busy && budget > 0) begin
        img_valid = ($urandom_range(0, 2) != 0);
        start     = ($urandom_range(0, 3) == 0);
`ifdef PRESENT_PAUSE_EN
        pause     = ($urandom_range(0, 4) == 0);
`endif
        num_images       = CNT_W'($urandom);
        cycles_per_image = CNT_W'($urandom);
        step(1);
        budget--;
      end
      start = 1'b0;
`ifdef PRESENT_PAUSE_EN
      pause = 1'b0;
`endif
      if (budget == 0) chk("random_timeout", 1, 0);
      step($urandom_range(0, 3));
    end

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_present_ctrl.md
IMAGE_PRESENT_CTRL -- requirements
Module: image_present_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the cycle counter, image counter and their configuration inputs.
REQ-002 SHALL have parameter REST_W, default 8: width of the rest-period counter and rest_cycles.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle run request.
REQ-006 SHALL have port num_images, input, CNT_W bits: images per run.
REQ-007 SHALL have port cycles_per_image, input, CNT_W bits: encoder-enabled cycles per image.
REQ-008 SHALL have port rest_cycles, input, REST_W bits: idle cycles between images.
REQ-009 SHALL have port img_valid, input, 1 bit: the image source holds a valid pixel array.
REQ-010 SHALL have port img_ready, output, 1 bit: the controller accepts the image; the transfer occurs when img_valid and img_ready are both 1.
REQ-011 SHALL have port enc_enable, output, 1 bit: drives the LFSR spike encoder enable.
REQ-012 SHALL have port enc_clear, output, 1 bit: one-cycle clear of encoder and downstream neuron state.
REQ-013 SHALL have port image_done, output, 1 bit: one-cycle pulse at the end of each presentation.
REQ-014 SHALL have port run_done, output, 1 bit: one-cycle pulse at the end of the run.
REQ-015 SHALL have port busy, output, 1 bit: 1 in every state except IDLE.
REQ-016 SHALL have port image_index, output, CNT_W bits: zero-based index of the current image.
REQ-017 SHALL have port cycle_count, output, CNT_W bits: cycles elapsed in the current presentation.

Function
REQ-018 SHALL implement states IDLE, WAIT_IMG, CLEAR, PRESENT, REST, DONE.
REQ-019 IDLE: on start=1, latch num_images, cycles_per_image and rest_cycles; go to DONE if num_images=0, else go to WAIT_IMG.
REQ-020 Configuration inputs SHALL be ignored outside the start cycle of IDLE; start SHALL be ignored when busy=1.
REQ-021 WAIT_IMG: img_ready=1; on img_valid=1, go to CLEAR next cycle.
REQ-022 CLEAR: enc_clear=1 for exactly one cycle; cycle_count<=0; go to PRESENT.
REQ-023 PRESENT: enc_enable=1; cycle_count increments each cycle.
REQ-024 PRESENT SHALL exit after exactly max(cycles_per_image,1) cycles with enc_enable=1, so a latched value of 0 behaves as 1.
REQ-025 In the last PRESENT cycle, image_done SHALL be registered so that it pulses in the first cycle after PRESENT.
REQ-026 If image_index = latched num_images-1, the state after PRESENT SHALL be DONE.
REQ-027 Otherwise, the state after PRESENT SHALL be REST if rest_cycles>0, else WAIT_IMG, with image_index incremented on the transition.
REQ-028 REST: enc_enable=0 for exactly rest_cycles cycles, then go to WAIT_IMG.
REQ-029 DONE: run_done=1 for one cycle, then go to IDLE; image_index and cycle_count SHALL hold their values until the next start.
REQ-030 img_ready SHALL be 1 only in WAIT_IMG, and enc_enable SHALL be 1 only in PRESENT.
REQ-031 Counters SHALL never wrap within a run; comparisons SHALL be unsigned, full width.

Reset
REQ-032 While reset=0: state=IDLE; img_ready, enc_enable, enc_clear, image_done, run_done and busy are 0; image_index and cycle_count are 0; latched configuration is 0.
REQ-033 Reset asserted mid-run SHALL abort immediately with no run_done or image_done pulse.
REQ-034 After reset deassertion, the first start SHALL be honoured on the first rising edge.

Configuration
REQ-035 Macro PRESENT_PAUSE_EN defined: input port pause (1 bit) exists; while pause=1 in PRESENT or REST, state and counters freeze, enc_enable=0, and the remaining count is preserved.
REQ-036 Macro PRESENT_PAUSE_EN undefined: no pause port and no freeze logic; behaviour is identical to the defined case with pause=0.

Verification
REQ-037 Bench SHALL cover: num_images=2, cycles_per_image=5, rest_cycles=3, img_valid always 1 -> enc_enable high 5 cycles, low 3 plus handshake, high 5; two image_done pulses; one run_done.
REQ-038 Bench SHALL cover: num_images=0, start -> busy for 2 cycles, run_done pulse, enc_enable never 1.
REQ-039 Bench SHALL cover: cycles_per_image=0, rest_cycles=0, num_images=3 -> exactly 3 single-cycle enc_enable pulses, each preceded by enc_clear.
REQ-040 Bench SHALL cover: img_valid withheld 10 cycles in WAIT_IMG -> img_ready held 1, enc_enable 0, no progress until img_valid=1.
REQ-041 Bench SHALL cover: reset=0 at cycle 3 of PRESENT -> all outputs 0 asynchronously, no done pulses; a later start runs normally.
REQ-042 Bench SHALL cover, with PRESENT_PAUSE_EN defined: pause for 4 cycles mid-PRESENT with cycles_per_image=6 -> 6 total enc_enable cycles, image_done delayed by 4.
